// File: rtl/vga_text_sequencer.sv
// Typewriter-style message sequencer for the VGA letter renderer: stores a short message,
// reveals it one slot per tick, optionally loops, and answers per-slot letter lookups.
module vga_text_sequencer #(
  parameter int          NUM_SLOTS  = 8,
  parameter int          TICK_DIV   = 25_000_000,
  parameter int          HOLD_TICKS = 4,
  parameter logic [4:0]  BLANK_CODE = 5'd31,
  localparam int         AW = $clog2(NUM_SLOTS),
  localparam int         CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [4:0]    wr_letter,
  input  logic [CW-1:0] msg_len,
  input  logic [1:0]    theme_in,
  input  logic          start,
  input  logic          stop,
  input  logic          loop_en,
  input  logic [AW-1:0] slot_sel,
  output logic [4:0]    letter_out,
  output logic [1:0]    theme_out,
  output logic          busy,
  output logic          done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] SLOTS_MAX = CW'(NUM_SLOTS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS);

  typedef enum logic [1:0] {IDLE, TYPE, SHOW} state_t;

  state_t        state;
  logic [CW-1:0] reveal_cnt;
  logic [CW-1:0] len_q;
  logic [PW-1:0] prescaler;
  logic [HW-1:0] hold_cnt;
  logic [4:0]    msg [NUM_SLOTS];

  logic          tick;
  logic [CW-1:0] len_clamped;
  logic          slot_revealed;

  assign tick          = (state != IDLE) && (prescaler == TICK_LAST);
  assign len_clamped   = (msg_len > SLOTS_MAX) ? SLOTS_MAX : msg_len;
  assign slot_revealed = ({1'b0, slot_sel} < reveal_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      reveal_cnt <= '0;
      len_q      <= '0;
      prescaler  <= '0;
      hold_cnt   <= '0;
      letter_out <= BLANK_CODE;
      theme_out  <= 2'b00;
      busy       <= 1'b0;
      done       <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) msg[i] <= BLANK_CODE;
    end else begin
      // Lookup uses the pre-edge message, so a same-cycle write to the read slot returns the old code.
      letter_out <= (state != IDLE && slot_revealed) ? msg[slot_sel] : BLANK_CODE;
      if (wr_en) msg[wr_addr] <= wr_letter;
      done <= 1'b0;

      if (stop) begin
        state      <= IDLE;
        reveal_cnt <= '0;
        prescaler  <= '0;
        hold_cnt   <= '0;
        busy       <= 1'b0;
      end else if (start) begin
        len_q      <= len_clamped;
        theme_out  <= theme_in;
        reveal_cnt <= '0;
        hold_cnt   <= '0;
        prescaler  <= '0;
        if (len_clamped == '0) begin
          state <= SHOW;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state <= TYPE;
          busy  <= 1'b1;
        end
      end else begin
        if (state != IDLE) prescaler <= tick ? '0 : prescaler + PW'(1);
        case (state)
          TYPE: if (tick) begin
            reveal_cnt <= reveal_cnt + CW'(1);
            if (reveal_cnt + CW'(1) == len_q) begin
              state <= SHOW;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          SHOW: if (tick && loop_en) begin
            // Loop restart happens on the tick that brings the hold count to HOLD_TICKS.
            if (hold_cnt + HW'(1) == HOLD_LAST) begin
              state      <= TYPE;
              busy       <= 1'b1;
              reveal_cnt <= '0;
              hold_cnt   <= '0;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_text_sequencer.sv
// Self-checking bench for vga_text_sequencer: a cycle model predicts each cycle's outputs into a
// scoreboard queue, plus directed latency and reset checks.
module tb_vga_text_sequencer;

  localparam int TD   = 4;
  localparam int HT   = 2;
  localparam int NS   = 8;
  localparam logic [4:0] BL = 5'd31;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [4:0] wr_letter = '0;
  logic [3:0] msg_len = '0;
  logic [1:0] theme_in = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop_en = 1'b0;
  logic [2:0] slot_sel = '0;
  logic [4:0] letter_out;
  logic [1:0] theme_out;
  logic       busy;
  logic       done;

  vga_text_sequencer #(.NUM_SLOTS(NS), .TICK_DIV(TD), .HOLD_TICKS(HT), .BLANK_CODE(BL)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_letter(wr_letter),
    .msg_len(msg_len), .theme_in(theme_in), .start(start), .stop(stop), .loop_en(loop_en),
    .slot_sel(slot_sel), .letter_out(letter_out), .theme_out(theme_out), .busy(busy), .done(done)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model
  logic [4:0] m_msg [NS];
  int         m_state;  // 0 idle, 1 type, 2 show
  int         m_pre, m_rev, m_len, m_hold;
  logic [1:0] m_theme;
  logic       m_busy, m_done;
  logic [8:0] exp_q [$];

  task automatic model_reset();
    for (int i = 0; i < NS; i++) m_msg[i] = BL;
    m_state = 0; m_pre = 0; m_rev = 0; m_len = 0; m_hold = 0;
    m_theme = 2'b00; m_busy = 1'b0; m_done = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [4:0] nl;
    logic       tk;
    int         st;
    nl = (m_state != 0 && int'(slot_sel) < m_rev) ? m_msg[slot_sel] : BL;
    if (wr_en) m_msg[wr_addr] = wr_letter;
    m_done = 1'b0;
    st = m_state;
    tk = (st != 0) && (m_pre == TD - 1);
    if (stop) begin
      m_state = 0; m_rev = 0; m_pre = 0; m_hold = 0;
    end else if (start) begin
      m_len = (int'(msg_len) > NS) ? NS : int'(msg_len);
      m_theme = theme_in; m_rev = 0; m_hold = 0; m_pre = 0;
      if (m_len == 0) begin m_state = 2; m_done = 1'b1; end
      else m_state = 1;
    end else if (st != 0) begin
      m_pre = tk ? 0 : m_pre + 1;
      if (st == 1 && tk) begin
        m_rev++;
        if (m_rev == m_len) begin m_state = 2; m_done = 1'b1; end
      end else if (st == 2 && tk && loop_en) begin
        m_hold++;
        if (m_hold == HT) begin m_state = 1; m_rev = 0; m_hold = 0; end
      end
    end
    m_busy = (m_state == 1);
    exp_q.push_back({nl, m_theme, m_busy, m_done});
  endtask

  // driver: one clock; inputs already set, model predicts at the edge, scoreboard compares after
  task automatic step();
    logic [8:0] e;
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("queue_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check("letter", letter_out, e[8:4]);
      check("theme", theme_out, e[3:2]);
      check("busy", busy, e[1]);
      check("done", done, e[0]);
    end
    wr_en = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      slot_sel = 3'($urandom_range(0, NS - 1));
      step();
    end
  endtask

  task automatic sweep();
    for (int i = 0; i < NS; i++) begin
      slot_sel = 3'(i);
      step();
    end
    step();
  endtask

  task automatic write_slot(input int a, input int l);
    wr_en = 1'b1; wr_addr = 3'(a); wr_letter = 5'(l);
    slot_sel = 3'($urandom_range(0, NS - 1));
    step();
  endtask

  // start, then count cycles until done is seen (start cycle = 0)
  task automatic start_and_time(input int len, input int th, input int exp_cycles, input string tag);
    int n;
    msg_len = 4'(len); theme_in = 2'(th); start = 1'b1;
    slot_sel = 3'($urandom_range(0, NS - 1));
    step();
    n = 0;
    while (!done && n < 60) begin
      slot_sel = 3'($urandom_range(0, NS - 1));
      step();
      n++;
    end
    check(tag, n, exp_cycles);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: reset state
    check("rst_letter", letter_out, BL);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_theme", theme_out, 0);
    sweep();

    // 2: "GAME"
    write_slot(0, 6); write_slot(1, 0); write_slot(2, 12); write_slot(3, 4);
    msg_len = 4'd4; theme_in = 2'd2; start = 1'b1; step();
    check("game_busy", busy, 1);
    run(2);
    start_and_time(4, 2, 16, "game_done_lat");
    sweep();

    // same-cycle write and read of a revealed slot returns the old code
    wr_en = 1'b1; wr_addr = 3'd2; wr_letter = 5'd20; slot_sel = 3'd2; step();
    check("wr_same_old", letter_out, 12);
    slot_sel = 3'd2; step();
    check("wr_visible", letter_out, 20);

    // 3: clamped length with random content
    for (int i = 0; i < NS; i++) write_slot(i, $urandom_range(0, 30));
    start_and_time(12, 1, 32, "clamp_done_lat");
    sweep();

    // 4: zero length
    start_and_time(0, 3, 0, "zero_done_lat");
    check("zero_busy", busy, 0);
    sweep();

    // 5: start+stop together mid-TYPE, then restart
    msg_len = 4'd5; theme_in = 2'd1; start = 1'b1; step();
    run(8);
    start = 1'b1; stop = 1'b1; step();
    check("stop_busy", busy, 0);
    check("stop_theme", theme_out, 1);
    sweep();
    start_and_time(5, 1, 20, "restart_done_lat");

    // 6: looping "OK"
    write_slot(0, 14); write_slot(1, 10);
    loop_en = 1'b1;
    start_and_time(2, 2, 8, "ok_done_lat");
    run(7);
    slot_sel = 3'd0; step();
    check("loop_busy", busy, 1);
    slot_sel = 3'd0; step();
    check("loop_slot0_blank", letter_out, BL);
    run(30);
    loop_en = 1'b0;

    // async reset mid-TYPE
    msg_len = 4'd3; start = 1'b1; step();
    run(5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_letter", letter_out, BL);
    check("arst_theme", theme_out, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    start_and_time(8, 0, 32, "post_rst_done_lat");
    sweep();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
